mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: max consecutive data grants while if_req is pending before IF is forced a grant; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 if_req  input  1  fetch request; held high until if_rvalid pulse.
REQ-005 if_addr  input  32  fetch address; stable while if_req high.
REQ-006 if_flush  input  1  branch/jump redirect; discards the in-flight fetch response.
REQ-007 if_rdata  output  32  fetched instruction; valid with if_rvalid.
REQ-008 if_rvalid  output  1  one-cycle fetch completion pulse.
REQ-009 d_re / d_we  input  1 each  data read / write request; held until d_done.
REQ-010 d_addr, d_wdata  input  32 each  data address / write data.
REQ-011 d_wstrb  input  4  byte write strobes.
REQ-012 d_rdata  output  32  load data; valid with d_done on reads.
REQ-013 d_done  output  1  one-cycle data completion pulse (reads and writes).
REQ-014 mem_req  output  1  unified single-port memory request.
REQ-015 mem_we  output  1; mem_addr, mem_wdata  output  32 each; mem_wstrb  output  4.
REQ-016 mem_ready  input  1  memory accepts request this cycle.
REQ-017 mem_rvalid  input  1; mem_rdata  input  32  read response.

Function
REQ-018 One outstanding memory transaction at a time; FSM states IDLE, REQ, RESP, DONE.
REQ-019 IDLE: if any request pending, select owner, latch addr/we/wdata/wstrb, go REQ; else stay.
REQ-020 Arbitration: data beats IF, unless if_req is high and starve_cnt == STARVE_MAX, then IF wins.
REQ-021 starve_cnt: +1 on each data grant while if_req high (saturating at STARVE_MAX); cleared on IF grant or when a data grant is made with if_req low.
REQ-022 d_re and d_we both high: treated as write.
REQ-023 REQ: mem_req=1 with latched fields; hold all mem_* stable until mem_ready.
REQ-024 REQ & mem_ready: write -> DONE; read -> RESP; mem_req drops next cycle.
REQ-025 RESP: wait for mem_rvalid; on it capture mem_rdata into if_rdata or d_rdata, go DONE.
REQ-026 DONE: exactly one cycle; pulse if_rvalid or d_done for owner; no arbitration; then IDLE.
REQ-027 Requesters deassert or change request in the cycle after the done pulse; IDLE re-samples then.
REQ-028 Minimum read latency: request at cycle 0, mem_req cycle 1, rvalid cycle 2 earliest, done pulse cycle 3.
REQ-029 if_flush high at any cycle while owner=IF and FSM in REQ/RESP/DONE sets drop flag; transaction completes on memory side; if_rvalid suppressed; flag cleared on return to IDLE.
REQ-030 if_flush in IDLE has no effect; if_flush never affects data transactions.
REQ-031 mem_rvalid outside RESP is ignored.
REQ-032 if_rdata/d_rdata hold last captured value until next capture.

Reset
REQ-033 rst asserted: state IDLE, starve_cnt 0, drop flag 0, all outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_rdata, if_rvalid, d_rdata, d_done).
REQ-034 rst mid-transaction aborts it with no done pulse; memory-side response after release is ignored per REQ-031.

Verification
REQ-035 if_req, if_addr=0x100; mem_ready=1; rvalid next cycle with 0x00000013 -> if_rvalid at cycle 3, if_rdata=0x00000013.
REQ-036 if_req and d_re same cycle -> data served first (d_done), then IF (if_rvalid); no overlap of mem_req.
REQ-037 d_we, addr 0x2000, wdata 0xDEADBEEF, wstrb 0xF, mem_ready delayed 3 cycles -> mem_* stable for 4 cycles, d_done one pulse, no RESP state.
REQ-038 if_req held, d_re reasserted back-to-back, STARVE_MAX=4 -> exactly 4 data grants, then IF granted; starve_cnt returns to 0.
REQ-039 if_flush during RESP of fetch -> no if_rvalid, FSM returns to IDLE, next fetch completes normally.
REQ-040 rst pulsed while in RESP -> all outputs 0 immediately, late mem_rvalid ignored, no done pulse.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - unified single-port memory bus between the arbiter and memory
//
// Signals:
//   mem_req                  request valid, held with all fields until mem_ready
//   mem_we                   1 = write, 0 = read
//   mem_addr/wdata/wstrb     address, write data, byte strobes
//   mem_ready                memory accepts the request this cycle
//   mem_rvalid/mem_rdata     read response
// Modports: master (arbiter side), slave (memory side).
interface mem_arbiter_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates instruction fetch and data access onto one memory port
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   if_req, if_addr, if_flush        fetch request, address, redirect (drops in-flight fetch)
//   if_rdata, if_rvalid              fetched word, one-cycle completion pulse
//   d_re, d_we, d_addr, d_wdata,
//   d_wstrb                          data read/write request and write fields
//   d_rdata, d_done                  load data, one-cycle completion pulse
//   mem                              memory bus (mem_arbiter_if.master)
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_rdata,
    output logic        if_rvalid,
    input  logic        d_re,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        d_done,
    mem_arbiter_if.master mem
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        owner_if;
    logic        drop;
    logic [3:0]  starve_cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        data_req;
    logic        any_req;
    logic        grant_if;

    assign data_req = d_re | d_we;
    assign any_req  = if_req | data_req;
    // Data normally wins; a fetch that has watched STARVE_MAX data grants go by takes the next slot.
    assign grant_if = if_req & (~data_req | (starve_cnt == STARVE_LIM));

    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_wstrb = wstrb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        mem.mem_req = 1'b0;
        if_rvalid   = 1'b0;
        d_done      = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ready) begin
                    state_nxt = we_q ? DONE : RESP;
                end
            end
            RESP: begin
                if (mem.mem_rvalid) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                // A flush arriving in the DONE cycle itself must also kill the pulse,
                // since the drop flag would only register after it.
                if (owner_if) begin
                    if_rvalid = ~drop & ~if_flush;
                end else begin
                    d_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_if   <= 1'b0;
            drop       <= 1'b0;
            starve_cnt <= 4'd0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            if_rdata   <= 32'd0;
            d_rdata    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    drop <= 1'b0;
                    if (any_req) begin
                        owner_if <= grant_if;
                        if (grant_if) begin
                            we_q       <= 1'b0;
                            addr_q     <= if_addr;
                            wdata_q    <= 32'd0;
                            wstrb_q    <= 4'd0;
                            starve_cnt <= 4'd0;
                        end else begin
                            // d_we wins over d_re when both are raised.
                            we_q    <= d_we;
                            addr_q  <= d_addr;
                            wdata_q <= d_wdata;
                            wstrb_q <= d_wstrb;
                            if (if_req) begin
                                starve_cnt <= (starve_cnt == STARVE_LIM) ? STARVE_LIM
                                                                         : starve_cnt + 4'd1;
                            end else begin
                                starve_cnt <= 4'd0;
                            end
                        end
                    end
                end
                RESP: begin
                    if (mem.mem_rvalid) begin
                        if (owner_if) begin
                            if_rdata <= mem.mem_rdata;
                        end else begin
                            d_rdata <= mem.mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
            if (owner_if && if_flush && (state != IDLE)) begin
                drop <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;
    localparam int STARVE_MAX = 4;

    typedef struct {
        int          kind;   // 0 fetch, 1 load, 2 store
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          cyc;    // expected completion cycle, -1 = don't care
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_re, d_we, d_done;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;

    mem_arbiter_if mem_bus();

    mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_rdata  (if_rdata),
        .if_rvalid (if_rvalid),
        .d_re      (d_re),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem       (mem_bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;
    exp_t sb[$];
    exp_t mon_e;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0000_0013 : {a[15:0] ^ 16'hA5C3, a[15:0]};
    endfunction

    function automatic void push_exp(input int kind, input logic [31:0] a, input logic [31:0] d,
                                     input logic [3:0] s, input int c);
        exp_t e;
        e.kind = kind; e.addr = a; e.data = d; e.strb = s; e.cyc = c;
        sb.push_back(e);
    endfunction

    // Memory model: programmable accept and response delays, records write fields and
    // flags any change of the request fields while mem_req waits for mem_ready.
    int          ready_delay = 0;
    int          rvalid_delay = 0;
    int          w_cnt = 0;
    int          rv_cnt = 0;
    bit          rv_pending = 0;
    logic [31:0] rv_addr = 0;
    logic [31:0] wr_addr = 0, wr_data = 0;
    logic [3:0]  wr_strb = 0;
    int          acc_cyc = 0;
    int          req_cycles = 0;
    bit          unstable = 0;
    logic [68:0] first_fields = 0;

    initial begin
        mem_bus.mem_ready  = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = 32'd0;
        forever begin
            @(posedge clk); #1;
            mem_bus.mem_ready  = 1'b0;
            mem_bus.mem_rvalid = 1'b0;
            if (rv_pending) begin
                if (rv_cnt >= rvalid_delay) begin
                    mem_bus.mem_rvalid = 1'b1;
                    mem_bus.mem_rdata  = rd_fn(rv_addr);
                    rv_pending = 0;
                end else begin
                    rv_cnt++;
                end
            end
            if (mem_bus.mem_req) begin
                if (w_cnt == 0) begin
                    first_fields = {mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata, mem_bus.mem_wstrb};
                end else if (first_fields !== {mem_bus.mem_we, mem_bus.mem_addr,
                                               mem_bus.mem_wdata, mem_bus.mem_wstrb}) begin
                    unstable = 1;
                end
                if (w_cnt >= ready_delay) begin
                    mem_bus.mem_ready = 1'b1;
                    req_cycles = w_cnt + 1;
                    acc_cyc = cyc;
                    w_cnt = 0;
                    if (mem_bus.mem_we) begin
                        wr_addr = mem_bus.mem_addr;
                        wr_data = mem_bus.mem_wdata;
                        wr_strb = mem_bus.mem_wstrb;
                    end else begin
                        rv_pending = 1;
                        rv_cnt = 0;
                        rv_addr = mem_bus.mem_addr;
                    end
                end else begin
                    w_cnt++;
                end
            end
        end
    end

    // Scoreboard: every completion pulse pops the next expected transaction.
    always @(negedge clk) begin
        if (!rst && (if_rvalid || d_done)) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_pulse", {30'd0, if_rvalid, d_done}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("owner", {31'd0, d_done}, (mon_e.kind == 0) ? 32'd0 : 32'd1);
                check_eq("single_pulse", {31'd0, if_rvalid & d_done}, 32'd0);
                if (mon_e.cyc >= 0) check_eq("latency", cyc, mon_e.cyc);
                if (if_rvalid) begin
                    check_eq("if_rdata", if_rdata, mon_e.data);
                end else if (mon_e.kind == 1) begin
                    check_eq("d_rdata", d_rdata, mon_e.data);
                end else begin
                    check_eq("st_addr", wr_addr, mon_e.addr);
                    check_eq("st_wdata", wr_data, mon_e.data);
                    check_eq("st_wstrb", {28'd0, wr_strb}, {28'd0, mon_e.strb});
                    check_eq("st_no_resp", cyc, acc_cyc + 1);
                end
            end
        end
    end

    task automatic wait_pulse(input bit is_if, input string tag);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            seen = is_if ? if_rvalid : d_done;
        end
        if (!seen) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_resp(input string tag);
        int n = 0;
        while (!mem_bus.mem_req && n < 50) begin @(negedge clk); n++; end
        while (mem_bus.mem_req && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_fetch(input logic [31:0] a, input int lat, input bit push);
        @(posedge clk); #1;
        if (push) push_exp(0, a, rd_fn(a), 4'd0, (lat >= 0) ? cyc + lat : -1);
        if_req = 1'b1;
        if_addr = a;
        wait_pulse(1'b1, "fetch");
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input int lat, input bit push);
        @(posedge clk); #1;
        if (push) push_exp(1, a, rd_fn(a), 4'd0, (lat >= 0) ? cyc + lat : -1);
        d_re = 1'b1;
        d_we = 1'b0;
        d_addr = a;
        wait_pulse(1'b0, "load");
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                            input bit also_re);
        @(posedge clk); #1;
        push_exp(2, a, w, s, -1);
        d_re = also_re;
        d_we = 1'b1;
        d_addr = a;
        d_wdata = w;
        d_wstrb = s;
        wait_pulse(1'b0, "store");
    endtask

    task automatic data_release();
        @(posedge clk); #1;
        d_re = 1'b0;
        d_we = 1'b0;
    endtask

    task automatic check_quiet(input string tag, input int cycles);
        bit saw = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (if_rvalid || d_done) saw = 1;
        end
        check_eq(tag, {31'd0, saw}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        if_req = 0; if_flush = 0; if_addr = 0;
        d_re = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        check_eq("rst_d_done", {31'd0, d_done}, 32'd0);
        check_eq("rst_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
        check_eq("rst_mem_we", {31'd0, mem_bus.mem_we}, 32'd0);
        check_eq("rst_mem_addr", mem_bus.mem_addr, 32'd0);
        check_eq("rst_mem_wdata", mem_bus.mem_wdata, 32'd0);
        check_eq("rst_mem_wstrb", {28'd0, mem_bus.mem_wstrb}, 32'd0);
        check_eq("rst_if_rdata", if_rdata, 32'd0);
        check_eq("rst_d_rdata", d_rdata, 32'd0);
        rst = 1'b0;

        // Minimum-latency fetch and load.
        do_fetch(32'h100, 3, 1'b1);
        do_load(32'h1000, 3, 1'b1);
        data_release();

        // Load with slow memory while if_flush is high: flush must not touch data.
        ready_delay = 1; rvalid_delay = 2;
        if_flush = 1'b1;
        do_load(32'h1234, 6, 1'b1);
        data_release();
        if_flush = 1'b0;

        // Store held off by mem_ready for 3 cycles; then d_re+d_we treated as a store.
        ready_delay = 3; rvalid_delay = 0;
        unstable = 0;
        do_store(32'h2000, 32'hDEAD_BEEF, 4'hF, 1'b0);
        data_release();
        check_eq("st_req_cycles", req_cycles, 32'd4);
        check_eq("st_stable", {31'd0, unstable}, 32'd0);
        ready_delay = 0;
        do_store(32'h2004, 32'h1234_5678, 4'b0101, 1'b1);
        data_release();

        // Simultaneous fetch and load: data first.
        push_exp(1, 32'h3000, rd_fn(32'h3000), 4'd0, -1);
        push_exp(0, 32'h0200, rd_fn(32'h0200), 4'd0, -1);
        fork
            begin do_load(32'h3000, -1, 1'b0); data_release(); end
            do_fetch(32'h0200, -1, 1'b0);
        join
        check_eq("d_rdata_hold", d_rdata, rd_fn(32'h3000));

        // Starvation limit: four loads, then the waiting fetch, then the last load.
        for (int i = 0; i < 4; i++) push_exp(1, 32'h4000 + 32'(i * 4), rd_fn(32'h4000 + 32'(i * 4)), 4'd0, -1);
        push_exp(0, 32'h0280, rd_fn(32'h0280), 4'd0, -1);
        push_exp(1, 32'h4010, rd_fn(32'h4010), 4'd0, -1);
        fork
            do_fetch(32'h0280, -1, 1'b0);
            begin
                for (int i = 0; i < 5; i++) do_load(32'h4000 + 32'(i * 4), -1, 1'b0);
                data_release();
            end
        join
        check_eq("starve_cnt_cleared", {28'd0, dut.starve_cnt}, 32'd0);

        // Flush during RESP: response dropped, next fetch (flush raised in IDLE) completes.
        rvalid_delay = 2;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h400;
        wait_resp("flush_resp");
        @(posedge clk); #1;
        if_flush = 1'b1; if_req = 1'b0;
        @(posedge clk); #1;
        if_flush = 1'b0;
        check_quiet("flush_suppressed", 6);
        rvalid_delay = 0;
        @(posedge clk); #1;
        push_exp(0, 32'h404, rd_fn(32'h404), 4'd0, cyc + 3);
        if_req = 1'b1; if_addr = 32'h404; if_flush = 1'b1;
        @(posedge clk); #1;
        if_flush = 1'b0;
        wait_pulse(1'b1, "refetch");
        @(posedge clk); #1;
        if_req = 1'b0;

        // Reset while waiting in RESP; the late response must be ignored.
        rvalid_delay = 3;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h300;
        wait_resp("rst_resp");
        rst = 1'b1;
        #1;
        check_eq("mid_rst_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
        check_eq("mid_rst_mem_addr", mem_bus.mem_addr, 32'd0);
        check_eq("mid_rst_if_rdata", if_rdata, 32'd0);
        check_eq("mid_rst_d_rdata", d_rdata, 32'd0);
        check_eq("mid_rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        if_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_quiet("rst_no_done", 8);
        check_eq("late_rvalid_ignored", if_rdata, 32'd0);

        check_eq("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
